parity_serial_rx: RTL and testbench

//   Receive end of the team's odd-parity serial link. The transmit side forms the

---
 rtl/parity_link_pkg.sv | 16 +
 rtl/sync_2ff.sv | 18 +
 rtl/parity_serial_rx.sv | 105 ++++++++++
 tb/tb_parity_serial_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// parity_link_pkg: shared definitions for the odd-parity serial link (rx and tx).
//   IDLE..STOP     3-bit receiver/transmitter state encodings
//   PARITY_ODD_DEF default parity sense (1 = odd)
//   par_gen()      parity bit the transmitter appends to a data word
package parity_link_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam bit PARITY_ODD_DEF = 1'b1;
  // Zero-extension does not change a reduction XOR, so words up to 64 bits share this.
  function automatic logic par_gen(input logic [63:0] data);
    return ~^data;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset; both flops load RST_VAL
//   d_i    in  asynchronous input
//   q_o    out synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q_o, meta_q} <= {RST_VAL, RST_VAL};
    else        {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: deserialises start/data(LSB first)/parity/stop frames and checks them.
//   clk           in  clock
//   rst_n         in  asynchronous active-low reset
//   rx_i          in  serial line, idle high, asynchronous
//   data_o        out last received word, held until next valid_o
//   valid_o       out one-cycle strobe: data_o and error flags updated
//   parity_err_o  out parity mismatch (qualified by valid_o)
//   frame_err_o   out stop bit sampled low (qualified by valid_o)
//   busy_o        out receiver not idle
module parity_serial_rx
  import parity_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = PARITY_ODD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);
  localparam int HB = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);

  logic              rx_s;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shreg_q, data_q;
  logic              par_q, stop_q, stop_seen_q;
  logic              valid_q, perr_q, ferr_q;
  logic              half_end, bit_end, last_bit, done;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign half_end = cnt_q == CW'(HB - 1);
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_bit = idx_q == IW'(DATA_W - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rx_s ? IDLE : START;
      START:   state_d = !half_end ? START : (rx_s ? IDLE : DATA);
      DATA:    state_d = (bit_end && last_bit) ? PARITY : DATA;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = stop_seen_q ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end

  // The frame is delivered one cycle after the mid-stop sample, leaving STOP on the same edge.
  always_comb begin
    busy_o = state_q != IDLE;
    done   = (state_q == STOP) && stop_seen_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      stop_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      cnt_q       <= (state_q == IDLE || (state_q == START && half_end) || bit_end) ? '0 : cnt_q + CW'(1);
      idx_q       <= (state_q != DATA) ? '0 : (bit_end ? idx_q + IW'(1) : idx_q);
      stop_seen_q <= (state_q == STOP) && !stop_seen_q && bit_end;
      valid_q     <= done;
      if (state_q == DATA && bit_end)
        for (int i = 0; i < DATA_W; i++)
          if (idx_q == IW'(i)) shreg_q[i] <= rx_s;
      if (state_q == PARITY && bit_end) par_q <= rx_s;
      if (state_q == STOP && !stop_seen_q && bit_end) stop_q <= rx_s;
      if (done) begin
        data_q <= shreg_q;
        perr_q <= (^shreg_q ^ par_q) != PARITY_ODD;
        ferr_q <= ~stop_q;
      end
    end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
endmodule

// File: tb/tb_parity_serial_rx.sv
// tb_parity_serial_rx: scoreboard bench for parity_serial_rx (CLKS_PER_BIT=4, DATA_W=8, odd parity).
module tb_parity_serial_rx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int LAT = 2 + CPB / 2 + (DW + 2) * CPB + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    logic [31:0]   st;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_i = 1'b1;
  logic [DW-1:0] data_o;
  logic          valid_o, parity_err_o, frame_err_o, busy_o;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, nvalid = 0, last_cyc = 0, prev_cyc = 0;
  logic prev_v = 1'b0;

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      exp_t e;
      chk("valid_width", 32'(prev_v), 0);
      chk("sb_empty", 32'(q.size() == 0), 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data", 32'(data_o), 32'(e.d));
        chk("parity_err", 32'(parity_err_o), 32'(e.pe));
        chk("frame_err", 32'(frame_err_o), 32'(e.fe));
        chk("latency", 32'(cyc) - e.st, LAT);
      end
      prev_cyc = last_cyc;
      last_cyc = cyc;
      nvalid++;
    end
    prev_v = valid_o;
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    exp_t e;
    e.d  = d;
    e.pe = ((^d) ^ p) != 1'b1;
    e.fe = !s;
    e.st = 32'(cyc + 1);
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    rx_i = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv0;
    logic seen_busy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_perr", 32'(parity_err_o), 0);
    chk("rst_ferr", 32'(frame_err_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    send_frame(8'hA5, 1'b1, 1'b1);
    drain();
    chk("idle_busy", 32'(busy_o), 0);

    send_frame(8'h03, 1'b0, 1'b1);
    drain();
    repeat (3) @(posedge clk); #1;
    chk("perr_hold", 32'(parity_err_o), 1);
    chk("valid_low", 32'(valid_o), 0);

    send_frame(8'h3C, 1'b1, 1'b0);
    drain();

    nv0 = nvalid;
    seen_busy = 1'b0;
    rx_i = 1'b0;
    @(posedge clk); #1;
    rx_i = 1'b1;
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk);
      seen_busy |= busy_o;
    end
    chk("glitch_busy_seen", 32'(seen_busy), 1);
    chk("glitch_busy_end", 32'(busy_o), 0);
    chk("glitch_no_valid", 32'(nvalid - nv0), 0);
    @(posedge clk); #1;

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", 32'(data_o), 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_perr", 32'(parity_err_o), 0);
    chk("mid_rst_ferr", 32'(frame_err_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    nv0 = nvalid;
    send_frame(8'h5A, 1'b1, 1'b1);
    drain();
    chk("post_rst_count", 32'(nvalid - nv0), 1);

    nv0 = nvalid;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    drain();
    chk("b2b_count", 32'(nvalid - nv0), 2);
    chk("b2b_gap", 32'(last_cyc - prev_cyc), (DW + 3) * CPB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
